// File: rtl/key_event_decoder.sv
// Classifies debounced active-low key gestures into single-cycle events:
// short press, long press, hold-repeat and double click.
module key_event_decoder #(
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned LONG_CNT    = 100_000_000,
  parameter int unsigned DBL_GAP_CNT = 25_000_000,
  parameter int unsigned REPEAT_CNT  = 20_000_000,
  parameter bit          REPEAT_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       key_held
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_LONG   = 3'd2,
    ST_WAIT2  = 3'd3,
    ST_PRESS2 = 3'd4
  } state_e;

  localparam logic [1:0] EVT_SHORT  = 2'd0;
  localparam logic [1:0] EVT_LONG   = 2'd1;
  localparam logic [1:0] EVT_DOUBLE = 2'd2;
  localparam logic [1:0] EVT_REPEAT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CNT - 32'd1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 32'd1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_q;
  logic             evt_valid_q, evt_valid_d;
  logic [1:0]       evt_code_q, evt_code_d;
  logic             key_held_q, key_held_d;

  logic             fall_s, rise_s;
  logic [CNT_W-1:0] cnt_inc_s;

  assign fall_s    = key_q & ~key_in;
  assign rise_s    = ~key_q & key_in;
  // Saturating increment so the counter can never wrap back to zero.
  assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

  // Next-state, counter and event decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    evt_valid_d = 1'b0;
    evt_code_d  = EVT_SHORT;
    case (state_q)
      ST_IDLE: begin
        if (fall_s) begin
          state_d = ST_PRESS1;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_PRESS1: begin
        if (rise_s) begin
          state_d = ST_WAIT2;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == LONG_LAST) begin
          state_d     = ST_LONG;
          cnt_d       = CNT_ZERO;
          evt_valid_d = 1'b1;
          evt_code_d  = EVT_LONG;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_LONG: begin
        if (rise_s) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == REP_LAST) begin
          cnt_d = CNT_ZERO;
          if (REPEAT_EN) begin
            evt_valid_d = 1'b1;
            evt_code_d  = EVT_REPEAT;
          end else begin
            evt_valid_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_WAIT2: begin
        // A second press on the timeout cycle still counts as a double click.
        if (fall_s) begin
          state_d     = ST_PRESS2;
          cnt_d       = CNT_ZERO;
          evt_valid_d = 1'b1;
          evt_code_d  = EVT_DOUBLE;
        end else if (cnt_q == GAP_LAST) begin
          state_d     = ST_IDLE;
          cnt_d       = CNT_ZERO;
          evt_valid_d = 1'b1;
          evt_code_d  = EVT_SHORT;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_PRESS2: begin
        if (rise_s) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
    key_held_d = (state_d == ST_PRESS1) || (state_d == ST_LONG) || (state_d == ST_PRESS2);
  end

  // State, counter, key sample and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      evt_valid_q <= 1'b0;
      evt_code_q  <= EVT_SHORT;
      key_held_q  <= 1'b0;
    end else begin
      key_q       <= key_in;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      key_held_q  <= key_held_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Drives directed and random key gestures into two decoders (repeat on/off)
// and compares every cycle against a timestamp-based gesture model.
module tb_key_event_decoder;

  localparam int LONG_N = 20;
  localparam int GAP_N  = 10;
  localparam int REP_N  = 5;

  localparam int PH_IDLE  = 0;
  localparam int PH_DOWN1 = 1;
  localparam int PH_HELD  = 2;
  localparam int PH_GAP   = 3;
  localparam int PH_DOWN2 = 4;

  logic       clk;
  logic       rst_n;
  logic       key_in;
  logic       evt_valid_a, evt_valid_b;
  logic [1:0] evt_code_a, evt_code_b;
  logic       key_held_a, key_held_b;

  int n_checks;
  int n_fail;
  int cyc;

  // gesture model state: phase, timestamp of phase entry, previous key level
  int   ph;
  int   t_enter;
  logic prev_key;
  logic exp_valid, exp_valid_nr, exp_held;
  logic [1:0] exp_code;

  int ev_cnt[4];
  int ev_cnt_nr[4];

  key_event_decoder #(
    .CNT_W(8), .LONG_CNT(LONG_N), .DBL_GAP_CNT(GAP_N), .REPEAT_CNT(REP_N), .REPEAT_EN(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .evt_valid(evt_valid_a), .evt_code(evt_code_a), .key_held(key_held_a)
  );

  key_event_decoder #(
    .CNT_W(8), .LONG_CNT(LONG_N), .DBL_GAP_CNT(GAP_N), .REPEAT_CNT(REP_N), .REPEAT_EN(1'b0)
  ) u_dut_nr (
    .clk(clk), .rst_n(rst_n), .key_in(key_in),
    .evt_valid(evt_valid_b), .evt_code(evt_code_b), .key_held(key_held_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ph           = PH_IDLE;
    t_enter      = 0;
    prev_key     = 1'b1;
    exp_valid    = 1'b0;
    exp_valid_nr = 1'b0;
    exp_code     = 2'd0;
    exp_held     = 1'b0;
  endtask

  // One clock edge of the gesture rules, timed by elapsed cycles since phase entry.
  task automatic model_step();
    logic fall, rise;
    int   el;
    fall      = prev_key & ~key_in;
    rise      = ~prev_key & key_in;
    prev_key  = key_in;
    el        = cyc - t_enter;
    exp_valid = 1'b0;
    exp_code  = 2'd0;
    case (ph)
      PH_IDLE:  if (fall) begin ph = PH_DOWN1; t_enter = cyc; end
      PH_DOWN1: begin
        if (rise) begin
          ph = PH_GAP; t_enter = cyc;
        end else if (el == LONG_N) begin
          ph = PH_HELD; t_enter = cyc; exp_valid = 1'b1; exp_code = 2'd1;
        end
      end
      PH_HELD: begin
        if (rise) ph = PH_IDLE;
        else if (el % REP_N == 0) begin exp_valid = 1'b1; exp_code = 2'd3; end
      end
      PH_GAP: begin
        if (fall) begin
          ph = PH_DOWN2; exp_valid = 1'b1; exp_code = 2'd2;
        end else if (el == GAP_N) begin
          ph = PH_IDLE; exp_valid = 1'b1; exp_code = 2'd0;
        end
      end
      PH_DOWN2: if (rise) ph = PH_IDLE;
      default:  ph = PH_IDLE;
    endcase
    exp_valid_nr = exp_valid && (exp_code != 2'd3);
    exp_held     = (ph == PH_DOWN1) || (ph == PH_HELD) || (ph == PH_DOWN2);
  endtask

  task automatic check_outputs();
    check_val("held", key_held_a, exp_held);
    check_val("valid", evt_valid_a, exp_valid);
    if (exp_valid) check_val("code", evt_code_a, exp_code);
    check_val("held_nr", key_held_b, exp_held);
    check_val("valid_nr", evt_valid_b, exp_valid_nr);
    if (exp_valid_nr) check_val("code_nr", evt_code_b, exp_code);
  endtask

  task automatic tick(input logic k);
    key_in = k;
    @(posedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else model_step();
    @(negedge clk);
    check_outputs();
    if (evt_valid_a) ev_cnt[evt_code_a]++;
    if (evt_valid_b) ev_cnt_nr[evt_code_b]++;
  endtask

  task automatic run(input logic k, input int n);
    for (int i = 0; i < n; i++) tick(k);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) begin
      ev_cnt[i]    = 0;
      ev_cnt_nr[i] = 0;
    end
  endtask

  // Assert reset asynchronously (mid-cycle) and expect outputs to drop at once.
  task automatic pulse_reset(input logic k);
    key_in = k;
    rst_n  = 1'b0;
    #1;
    model_reset();
    check_outputs();
    run(k, 3);
    rst_n = 1'b1;
  endtask

  task automatic expect_counts(input string tag, input int c0, input int c1, input int c2,
                               input int c3, input int nr1);
    check_val({tag, "_short"}, ev_cnt[0], c0);
    check_val({tag, "_long"}, ev_cnt[1], c1);
    check_val({tag, "_double"}, ev_cnt[2], c2);
    check_val({tag, "_repeat"}, ev_cnt[3], c3);
    check_val({tag, "_nr_long"}, ev_cnt_nr[1], nr1);
    check_val({tag, "_nr_repeat"}, ev_cnt_nr[3], 0);
  endtask

  initial begin
    logic k;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    key_in   = 1'b1;
    model_reset();
    clear_counts();
    #1;
    check_outputs();
    run(1'b1, 3);
    rst_n = 1'b1;
    run(1'b1, 3);

    // single short press
    clear_counts();
    run(1'b0, 5); run(1'b1, 30);
    expect_counts("s1", 1, 0, 0, 0, 0);

    // long press with repeats, then release
    clear_counts();
    run(1'b0, 41); run(1'b1, 15);
    expect_counts("s2", 0, 1, 0, 4, 1);

    // double click with a long second hold
    clear_counts();
    run(1'b0, 3); run(1'b1, 4); run(1'b0, 50); run(1'b1, 15);
    expect_counts("s3", 0, 0, 1, 0, 0);

    // release exactly at the long threshold
    clear_counts();
    run(1'b0, 20); run(1'b1, 30);
    expect_counts("s4a", 1, 0, 0, 0, 0);

    // second press exactly at the gap timeout
    clear_counts();
    run(1'b0, 3); run(1'b1, 10); run(1'b0, 3); run(1'b1, 30);
    expect_counts("s4b", 0, 0, 1, 0, 0);

    // reset while in long hold, then a normal short press
    run(1'b0, 30);
    pulse_reset(1'b1);
    clear_counts();
    run(1'b1, 3); run(1'b0, 5); run(1'b1, 30);
    expect_counts("s5a", 1, 0, 0, 0, 0);

    // reset while waiting for a second press discards the short
    clear_counts();
    run(1'b0, 3); run(1'b1, 4);
    pulse_reset(1'b1);
    run(1'b1, 30);
    expect_counts("s5b", 0, 0, 0, 0, 0);

    // key held through reset release
    run(1'b0, 5);
    pulse_reset(1'b0);
    clear_counts();
    run(1'b0, 25); run(1'b1, 15);
    expect_counts("s6", 0, 1, 0, 0, 1);

    // random gestures with occasional resets
    k = 1'b1;
    for (int i = 0; i < 80; i++) begin
      k = ~k;
      run(k, $urandom_range(1, 35));
      if ($urandom_range(0, 19) == 0) pulse_reset(k);
    end
    run(1'b1, 30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
